// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mips_pkg
// Purpose  : Shared MIPS datapath definitions: ALU control encodings,
//            datapath widths and requester indices for the ALU arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;
    localparam int CNT_W   = 4;

    // Requester indices into the arbiter's grant/eligibility vectors
    localparam int REQ_EX = 0;
    localparam int REQ_BR = 1;

    // 4-bit alu_cnt encodings understood by the alu block
    typedef enum logic [CNT_W-1:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SLL = 4'b0011,
        ALU_SRL = 4'b0100,
        ALU_SRA = 4'b0101,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_op_e;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way arbiter, round-robin or fixed priority (requester 0).
//            Issues at most one grant per cycle and tracks the last winner.
// Ports    : clk, rst (async, active high)
//            elig[1:0]  in  - requesters eligible this cycle
//            grant[1:0] out - one-hot (or zero) grant, combinational
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] elig,
    output logic [1:0] grant
);

    // Index of the most recent winner; reset to 1 so requester 0 goes first
    logic r_last;

    if (FIXED_PRIO) begin : g_fixed
        assign grant = {elig[1] & ~elig[0], elig[0]};
    end else begin : g_rr
        // Under contention the requester that did not win last time goes
        assign grant = (&elig) ? (r_last ? 2'b01 : 2'b10) : elig;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if ((FIXED_PRIO == 1'b0) && (|grant)) begin
            r_last <= grant[1];
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one combinational MIPS alu between the execute stage
//            (requester 0) and the branch/address unit (requester 1).
//            Per-cycle arbitration, winner drives the alu bus, result/zero
//            captured into a one-entry response buffer per requester.
// Ports    : clk, rst (async, active high)
//            req{0,1}_valid/ready/cnt/in1/in2/shamt - op request channels
//            rsp{0,1}_valid/ready/result/zero        - response channels
//            alu_cnt/in1/in2/shamt out, alu_result/zero in - alu bus
//            busy - a grant is issued this cycle
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import mips_pkg::*;
#(
    parameter int DATA_W     = mips_pkg::DATA_W,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [3:0]         req0_cnt,
    input  logic [DATA_W-1:0]  req0_in1,
    input  logic [DATA_W-1:0]  req0_in2,
    input  logic [4:0]         req0_shamt,
    output logic               rsp0_valid,
    input  logic               rsp0_ready,
    output logic [DATA_W-1:0]  rsp0_result,
    output logic               rsp0_zero,

    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [3:0]         req1_cnt,
    input  logic [DATA_W-1:0]  req1_in1,
    input  logic [DATA_W-1:0]  req1_in2,
    input  logic [4:0]         req1_shamt,
    output logic               rsp1_valid,
    input  logic               rsp1_ready,
    output logic [DATA_W-1:0]  rsp1_result,
    output logic               rsp1_zero,

    output logic [3:0]         alu_cnt,
    output logic [DATA_W-1:0]  alu_in1,
    output logic [DATA_W-1:0]  alu_in2,
    output logic [4:0]         alu_shamt,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_zero,
    output logic               busy
);

    // Requester channels gathered into arrays indexed by requester number
    logic [1:0]          w_req_valid;
    logic [1:0]          w_rsp_ready;
    logic [1:0]          w_elig;
    logic [1:0]          w_grant;
    logic [CNT_W-1:0]    w_req_cnt   [2];
    logic [DATA_W-1:0]   w_req_in1   [2];
    logic [DATA_W-1:0]   w_req_in2   [2];
    logic [SHAMT_W-1:0]  w_req_shamt [2];

    logic                r_rsp_valid  [2];
    logic [DATA_W-1:0]   r_rsp_result [2];
    logic                r_rsp_zero   [2];

    assign w_req_valid         = {req1_valid, req0_valid};
    assign w_rsp_ready         = {rsp1_ready, rsp0_ready};
    assign w_req_cnt[REQ_EX]   = req0_cnt;
    assign w_req_cnt[REQ_BR]   = req1_cnt;
    assign w_req_in1[REQ_EX]   = req0_in1;
    assign w_req_in1[REQ_BR]   = req1_in1;
    assign w_req_in2[REQ_EX]   = req0_in2;
    assign w_req_in2[REQ_BR]   = req1_in2;
    assign w_req_shamt[REQ_EX] = req0_shamt;
    assign w_req_shamt[REQ_BR] = req1_shamt;

    rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .elig  (w_elig),
        .grant (w_grant)
    );

    assign req0_ready = w_grant[REQ_EX];
    assign req1_ready = w_grant[REQ_BR];
    assign busy       = |w_grant;

    // Winner drives the alu bus; an idle bus is forced to zero
    always_comb begin
        alu_cnt   = '0;
        alu_in1   = '0;
        alu_in2   = '0;
        alu_shamt = '0;
        if (w_grant[REQ_EX]) begin
            alu_cnt   = w_req_cnt[REQ_EX];
            alu_in1   = w_req_in1[REQ_EX];
            alu_in2   = w_req_in2[REQ_EX];
            alu_shamt = w_req_shamt[REQ_EX];
        end else if (w_grant[REQ_BR]) begin
            alu_cnt   = w_req_cnt[REQ_BR];
            alu_in1   = w_req_in1[REQ_BR];
            alu_in2   = w_req_in2[REQ_BR];
            alu_shamt = w_req_shamt[REQ_BR];
        end
    end

    for (genvar n = 0; n < 2; n++) begin : g_rsp
        // A requester may issue only if its slot is empty or draining now,
        // which is what allows back-to-back issue at full rate.
        assign w_elig[n] = w_req_valid[n] & (~r_rsp_valid[n] | w_rsp_ready[n]);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rsp_valid[n]  <= 1'b0;
                r_rsp_result[n] <= '0;
                r_rsp_zero[n]   <= 1'b0;
            end else if (w_grant[n]) begin
                // New result wins over a same-cycle consume
                r_rsp_valid[n]  <= 1'b1;
                r_rsp_result[n] <= alu_result;
                r_rsp_zero[n]   <= alu_zero;
            end else if (r_rsp_valid[n] && w_rsp_ready[n]) begin
                r_rsp_valid[n]  <= 1'b0;
            end
        end
    end

    assign rsp0_valid  = r_rsp_valid[REQ_EX];
    assign rsp0_result = r_rsp_result[REQ_EX];
    assign rsp0_zero   = r_rsp_zero[REQ_EX];
    assign rsp1_valid  = r_rsp_valid[REQ_BR];
    assign rsp1_result = r_rsp_result[REQ_BR];
    assign rsp1_zero   = r_rsp_zero[REQ_BR];

endmodule : alu_arbiter
`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single MIPS `alu` instance between two requesters. Requester 0 is the execute stage; requester 1 is the branch/address unit.
- Arbitrates per cycle, drives the ALU operand/control bus from the winner, and registers `result`/`zero` into a per-requester response buffer.
- Sits between the datapath and `alu`; the `alu` itself is unchanged and combinational.

Parameters:
- DATA_W, 32, operand/result width.
- FIXED_PRIO, 0, 0 = round-robin; 1 = requester 0 always wins.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req0_valid  in  1  requester 0 has an op.
- req0_ready  out  1  requester 0 op accepted this cycle.
- req0_cnt  in  4  ALU control code.
- req0_in1  in  DATA_W  operand 1.
- req0_in2  in  DATA_W  operand 2.
- req0_shamt  in  5  shift amount.
- rsp0_valid  out  1  response 0 held.
- rsp0_ready  in  1  requester 0 consumes response.
- rsp0_result  out  DATA_W  registered ALU result.
- rsp0_zero  out  1  registered ALU zero flag.
- req1_* / rsp1_*: same as the requester 0 set, for requester 1.
- alu_cnt  out  4  to alu.alu_cnt.
- alu_in1  out  DATA_W  to alu.input1.
- alu_in2  out  DATA_W  to alu.input2.
- alu_shamt  out  5  to alu.shamt.
- alu_result  in  DATA_W  from alu.result.
- alu_zero  in  1  from alu.zero.
- busy  out  1  a grant is issued this cycle.

Behaviour:
- Reset (async, rst=1):
  - rsp*_valid = 0; rsp*_result = 0; rsp*_zero = 0.
  - Round-robin pointer last = 1, so requester 0 has first priority.
  - Reset mid-transaction drops any accepted-but-unconsumed response.
- Eligibility:
  - elig_n = reqn_valid & (~rspn_valid | rspn_ready).
  - The response slot must be free or freeing this cycle.
- Grant (combinational, at most one per cycle):
  - FIXED_PRIO=1: requester 0 if eligible, else requester 1.
  - FIXED_PRIO=0, both eligible: the requester ≠ last wins.
  - FIXED_PRIO=0, one eligible: that one wins.
  - reqn_ready = grant_n. Ready may depend on valid; requesters must not make valid depend on ready.
  - Requester payload must stay stable while valid & ~ready.
- ALU drive:
  - With a grant, alu_* = winner's cnt/in1/in2/shamt, combinationally.
  - Without a grant, all alu_* = 0.
  - busy = |grant.
- Capture at the edge ending the grant cycle:
  - rspn_result ← alu_result; rspn_zero ← alu_zero; rspn_valid ← 1.
  - last ← n, updated in round-robin mode only.
- Latency:
  - Op accepted in cycle N; rspn_valid is high from cycle N+1.
  - Back-to-back issue to the same requester is allowed when rspn_ready=1 in the grant cycle; throughput is 1 op/cycle total.
- Consume: rspn_valid & rspn_ready & ~grant_n → rspn_valid ← 0. Result and zero hold their last value.
- Simultaneous consume and new grant for the same requester: the new result overwrites and valid stays 1.
- Backpressure:
  - While rspn_valid & ~rspn_ready, requester n is ineligible.
  - The other requester may use the ALU every cycle.
- No starvation in round-robin mode: under continuous contention, grants alternate 0,1,0,1. Fixed mode may starve requester 1 by design.
- No X propagation: unused responses hold their values; the ALU bus is zero when idle.

Decomposition:
- Shared package `mips_pkg` holds:
  - ALU control code constants (4-bit `alu_cnt` encodings).
  - DATA_W and SHAMT_W = 5.
  - Requester index constants REQ_EX = 0 and REQ_BR = 1.
- One natural sub-module, `rr_arb2`: a 2-way round-robin/fixed arbiter with elig[1:0] in, grant[1:0] out, and its `last` pointer register.
- Payload muxing and response buffers stay in `alu_arbiter`.

Test Plan:
- Reset, then idle:
  - rst pulse mid-cycle → rsp*_valid = 0 immediately.
  - alu_cnt = 0, alu_in1 = alu_in2 = 0, busy = 0.
  - last = 1.
- Single op:
  - req0 cnt=4'b0000, in1=0, in2=1, shamt=0.
  - alu_in1/alu_in2 match in the same cycle; req0_ready = 1.
  - Next cycle rsp0_valid = 1 and rsp0_result/zero equal the alu output sampled in the grant cycle, checked against the golden alu model.
- Contention, round-robin:
  - Both valid for 4 cycles with rsp*_ready = 1.
  - Grants are 0,1,0,1; results route to the matching rsp port.
- Contention, FIXED_PRIO=1:
  - Same stimulus → requester 0 granted every cycle; req1_ready stays 0.
- Backpressure:
  - rsp0_ready = 0 with rsp0_valid = 1, and req0 plus req1 valid → req1 granted each cycle, req0_ready = 0, rsp0 result held.
  - Assert rsp0_ready → req0 granted in the same cycle, and rsp0 is overwritten next cycle with valid kept high.
- Reset mid-operation:
  - Grant req1 (cnt=4'b0101, in2=32'h11111111), then assert rst before rsp1_ready.
  - rsp1_valid drops asynchronously; after release, the first contended grant goes to requester 0.
